decoder_link_rx: RTL and testbench



---
 rtl/decoder_link_pkg.sv | 23 ++
 rtl/decoder_link_fifo.sv | 65 ++++++
 rtl/decoder_link_rx.sv | 170 +++++++++++++++++
 tb/tb_decoder_link_rx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_link_pkg.sv
// Shared types, constants and helpers for the decoder link receiver.
// Imported by decoder_link_fifo and decoder_link_rx.
package decoder_link_pkg;

  localparam int CODE_W = 3;
  localparam int LINES  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [LINES-1:0] onehot(input logic [CODE_W-1:0] code);
    return 8'h01 << code;
  endfunction

  // Counter width sized so a one-bit counter still exists for parameters of 0 or 1.
  function automatic int cnt_w(input int p);
    return (p < 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/decoder_link_fifo.sv
// Small registered FIFO (power-of-two DEPTH) buffering received codes.
// A push is dropped when full and a pop is ignored when empty; there is no bypass.
module decoder_link_fifo
  import decoder_link_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = CODE_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/decoder_link_rx.sv
// Receive end of the encoded link: buffers 3-bit codes and replays them as one-hot lines.
// Optional odd-parity checking is enabled with `define DECODER_LINK_PARITY_EN.
//
// state | meaning
// IDLE  | link quiet, waiting for a buffered code
// DRIVE | one-hot pattern on dec_y, hold counter running
// GAP   | forced all-zero link, gap counter running
module decoder_link_rx
  import decoder_link_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CODE_W-1:0] dec_in,
  input  logic              EN_dec,
`ifdef DECODER_LINK_PARITY_EN
  input  logic              dec_par,
  output logic              err_par,
  output logic [7:0]        err_cnt,
`endif
  output logic              RDY_dec,
  output logic [LINES-1:0]  dec_y,
  output logic              dec_valid,
  output logic              RDY_idle
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int GAP_W  = cnt_w(GAP_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold;
  logic [GAP_W-1:0]    r_gap;
  logic [LINES-1:0]    r_y;
  logic                r_valid;

  state_t              w_state_nx;
  logic [HOLD_W-1:0]   w_hold_nx;
  logic [GAP_W-1:0]    w_gap_nx;
  logic [LINES-1:0]    w_y_nx;
  logic                w_valid_nx;

  logic [CODE_W-1:0]   w_head;
  logic [CNT_W-1:0]    w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;

  assign RDY_dec   = ~RST & ~w_full;
  assign RDY_idle  = ~RST & (r_state == IDLE) & (w_count == '0);
  assign dec_y     = r_y;
  assign dec_valid = r_valid;
  assign w_accept  = EN_dec & RDY_dec;

`ifdef DECODER_LINK_PARITY_EN
  logic       w_par_ok;
  logic       r_err_par;
  logic [7:0] r_err_cnt;

  // Odd parity: a good code has an odd number of ones across {dec_par, dec_in}.
  assign w_par_ok = ^{dec_par, dec_in};
  assign w_push   = w_accept & w_par_ok;
  assign err_par  = r_err_par;
  assign err_cnt  = r_err_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err_par <= 1'b0;
      r_err_cnt <= 8'h00;
    end else begin
      r_err_par <= w_accept & ~w_par_ok;
      if (w_accept && !w_par_ok && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end
`else
  assign w_push = w_accept;
`endif

  decoder_link_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_push  (w_push),
    .i_din   (dec_in),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nx = r_state;
    w_hold_nx  = r_hold;
    w_gap_nx   = r_gap;
    w_y_nx     = r_y;
    w_valid_nx = r_valid;
    w_pop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_y_nx     = onehot(w_head);
          w_valid_nx = 1'b1;
          w_hold_nx  = HOLD_LD;
          w_state_nx = DRIVE;
        end
      end
      DRIVE: begin
        if (r_hold != '0) begin
          w_hold_nx = r_hold - 1'b1;
        end else if (GAP_CYCLES == 0 && !w_empty) begin
          // Back-to-back reload keeps the link busy with no zero cycle.
          w_pop      = 1'b1;
          w_y_nx     = onehot(w_head);
          w_hold_nx  = HOLD_LD;
        end else if (GAP_CYCLES == 0) begin
          w_y_nx     = '0;
          w_valid_nx = 1'b0;
          w_state_nx = IDLE;
        end else begin
          w_y_nx     = '0;
          w_valid_nx = 1'b0;
          w_gap_nx   = GAP_LD;
          w_state_nx = GAP;
        end
      end
      GAP: begin
        if (r_gap != '0) begin
          w_gap_nx = r_gap - 1'b1;
        end else begin
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_y_nx     = '0;
        w_valid_nx = 1'b0;
        w_state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_gap   <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_hold  <= w_hold_nx;
      r_gap   <= w_gap_nx;
      r_y     <= w_y_nx;
      r_valid <= w_valid_nx;
    end
  end

endmodule

// File: tb/tb_decoder_link_rx.sv
// Bench for decoder_link_rx: three parameterisations, directed tables/sequences
// and random traffic checked against a timeline model of the link.
module tb_decoder_link_rx;

  localparam int NI = 3;

  function automatic int p_d(input int i); return (i == 2) ? 4 : 2; endfunction
  function automatic int p_h(input int i); return (i == 0) ? 1 : ((i == 1) ? 4 : 2); endfunction
  function automatic int p_g(input int i); return (i == 2) ? 3 : 0; endfunction

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [NI-1:0]       rst, en, par, rdy, valid, idle;
  logic [NI-1:0][2:0]  din;
  logic [NI-1:0][7:0]  y;
  logic [NI-1:0]       err_par;
  logic [NI-1:0][7:0]  err_cnt;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    decoder_link_rx #(
      .DEPTH       ((g == 2) ? 4 : 2),
      .HOLD_CYCLES ((g == 0) ? 1 : ((g == 1) ? 4 : 2)),
      .GAP_CYCLES  ((g == 2) ? 3 : 0)
    ) u_dut (
      .CLK       (CLK),
      .RST       (rst[g]),
      .dec_in    (din[g]),
      .EN_dec    (en[g]),
`ifdef DECODER_LINK_PARITY_EN
      .dec_par   (par[g]),
      .err_par   (err_par[g]),
      .err_cnt   (err_cnt[g]),
`endif
      .RDY_dec   (rdy[g]),
      .dec_y     (y[g]),
      .dec_valid (valid[g]),
      .RDY_idle  (idle[g])
    );
  end

`ifndef DECODER_LINK_PARITY_EN
  assign err_par = '0;
  assign err_cnt = '0;
`endif

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s inst%0d: got %0h expected %0h (t=%0t)", name, i, act, exp, $time);
  endtask

  // Timeline model: codes queue up; a popped code occupies the link for H cycles,
  // then the link needs G zero cycles plus one idle cycle (none at all when G==0).
  int      q[NI][$];
  longint  lp[NI];
  bit      has_lp[NI];
  int      lcode[NI];
  bit      mvalid[NI];
  bit      m_errp[NI];
  int      m_errc[NI];
  longint  e = 0;

  function automatic bit par_ok(input int i);
`ifdef DECODER_LINK_PARITY_EN
    return ^{par[i], din[i]};
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [7:0] m_y(input int i);
    if (has_lp[i] && e >= lp[i] && e <= lp[i] + p_h(i) - 1) return 8'h01 << lcode[i];
    return 8'h00;
  endfunction

  function automatic bit m_idle(input int i);
    return !has_lp[i] || (e >= lp[i] + p_h(i) + p_g(i));
  endfunction

  task automatic model_edge(input int i);
    int sz;
    longint earliest;
    if (rst[i]) begin
      q[i].delete();
      has_lp[i] = 1'b0;
      mvalid[i] = 1'b1;
      m_errp[i] = 1'b0;
      m_errc[i] = 0;
      return;
    end
    sz = q[i].size();
    earliest = has_lp[i] ? lp[i] + p_h(i) + ((p_g(i) == 0) ? 0 : p_g(i) + 1) : 0;
    if (sz > 0 && e >= earliest) begin
      lcode[i]  = q[i].pop_front();
      lp[i]     = e;
      has_lp[i] = 1'b1;
    end
    m_errp[i] = 1'b0;
    if (en[i] && sz < p_d(i)) begin
      if (par_ok(i)) q[i].push_back(int'(din[i]));
      else begin
        m_errp[i] = 1'b1;
        if (m_errc[i] < 255) m_errc[i]++;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      if (mvalid[i]) begin
        chk("m_y", i, y[i], m_y(i));
        chk("m_valid", i, valid[i], |m_y(i));
        chk("m_rdy", i, rdy[i], !rst[i] && q[i].size() < p_d(i));
        chk("m_idle", i, idle[i], !rst[i] && m_idle(i) && q[i].size() == 0);
`ifdef DECODER_LINK_PARITY_EN
        chk("m_errp", i, err_par[i], m_errp[i]);
        chk("m_errc", i, err_cnt[i], m_errc[i]);
`endif
      end
    end
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge CLK);
    e++;
    for (int i = 0; i < NI; i++) model_edge(i);
    @(negedge CLK);
  endtask

  task automatic quiet();
    rst = '0; en = '0;
    for (int i = 0; i < NI; i++) begin
      din[i] = 3'd0;
      par[i] = 1'b1;
    end
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    logic [2:0] din;
    logic [7:0] y;
    bit         v;
    bit         rdy;
    bit         idl;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] exp_y[$];

  initial begin
    quiet();
    for (int i = 0; i < NI; i++) begin
      has_lp[i] = 0; mvalid[i] = 0; m_errp[i] = 0; m_errc[i] = 0; lcode[i] = 0; lp[i] = 0;
    end

    // Instance 0 (H=1, G=0): reset, single code 5, then codes 0..7 back-to-back.
    tbl.push_back('{1, 0, 3'd0, 8'h00, 0, 0, 0});
    tbl.push_back('{0, 1, 3'd5, 8'h00, 0, 1, 0});
    tbl.push_back('{0, 0, 3'd0, 8'h20, 1, 1, 0});
    tbl.push_back('{0, 0, 3'd0, 8'h00, 0, 1, 1});
    for (int k = 0; k < 8; k++) begin
      logic [7:0] one;
      one = 8'h01;
      tbl.push_back('{0, 1, 3'(k), (k == 0) ? 8'h00 : one << (k - 1), k != 0, 1, 0});
    end
    tbl.push_back('{0, 0, 3'd0, 8'h80, 1, 1, 0});
    tbl.push_back('{0, 0, 3'd0, 8'h00, 0, 1, 1});

    foreach (tbl[k]) begin
      quiet();
      rst    = {NI{tbl[k].rst}};
      en[0]  = tbl[k].en;
      din[0] = tbl[k].din;
      par[0] = ~^tbl[k].din;
      tick();
      chk("tbl_y", 0, y[0], tbl[k].y);
      chk("tbl_valid", 0, valid[0], tbl[k].v);
      chk("tbl_rdy", 0, rdy[0], tbl[k].rdy);
      chk("tbl_idle", 0, idle[0], tbl[k].idl);
    end

    // Instance 1 (DEPTH=2, H=4): codes 2,3,4 then 6 held while full.
    exp_y = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h08, 8'h08, 8'h08, 8'h08,
              8'h10, 8'h10, 8'h10, 8'h10, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00};
    for (int c = 1; c <= 18; c++) begin
      quiet();
      en[1]  = (c <= 7);
      din[1] = (c == 1) ? 3'd2 : (c == 2) ? 3'd3 : (c == 3) ? 3'd4 : 3'd6;
      par[1] = ~^din[1];
      #1;
      if (c >= 4 && c <= 6) chk("full_rdy", 1, rdy[1], 0);
      if (c == 7) chk("full_rdy_reopen", 1, rdy[1], 1);
      tick();
      chk("full_y", 1, y[1], exp_y[c-1]);
    end
    chk("full_idle_end", 1, idle[1], 1);

    // Instance 2 (H=2, G=3): codes 3 then 6.
    exp_y = '{8'h00, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h40,
              8'h00, 8'h00, 8'h00, 8'h00};
    for (int c = 1; c <= 13; c++) begin
      quiet();
      en[2]  = (c <= 2);
      din[2] = (c == 1) ? 3'd3 : 3'd6;
      par[2] = ~^din[2];
      tick();
      chk("gap_y", 2, y[2], exp_y[c-1]);
      if (c == 12) chk("gap_not_idle", 2, idle[2], 0);
    end
    chk("gap_idle_end", 2, idle[2], 1);

    // Instance 1: reset while 8'h10 is driven with code 1 buffered.
    for (int c = 1; c <= 2; c++) begin
      quiet();
      en[1] = 1'b1;
      din[1] = (c == 1) ? 3'd4 : 3'd1;
      par[1] = ~^din[1];
      tick();
    end
    chk("rst_mid_y_before", 1, y[1], 8'h10);
    quiet();
    rst[1] = 1'b1;
    #1;
    chk("rst_mid_rdy_gated", 1, rdy[1], 0);
    chk("rst_mid_idle_gated", 1, idle[1], 0);
    tick();
    chk("rst_mid_y", 1, y[1], 8'h00);
    chk("rst_mid_valid", 1, valid[1], 0);
    quiet();
    #1;
    chk("rst_mid_empty", 1, idle[1], 1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rst_mid_no_replay", 1, y[1], 8'h00);
    end

`ifdef DECODER_LINK_PARITY_EN
    quiet();
    en[0] = 1'b1; din[0] = 3'd1; par[0] = 1'b1;
    tick();
    chk("par_err_pulse", 0, err_par[0], 1);
    chk("par_err_cnt", 0, err_cnt[0], 1);
    quiet();
    tick();
    chk("par_err_clear", 0, err_par[0], 0);
    chk("par_no_output", 0, y[0], 8'h00);
    en[0] = 1'b1; din[0] = 3'd1; par[0] = 1'b0;
    tick();
    quiet();
    tick();
    chk("par_good_y", 0, y[0], 8'h02);
    chk("par_good_cnt", 0, err_cnt[0], 1);
`endif

    // Random traffic on all instances, checked every cycle by the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NI; i++) begin
        rst[i] = ($urandom_range(0, 59) == 0);
        en[i]  = ($urandom_range(0, 2) != 0);
        din[i] = 3'($urandom_range(0, 7));
        par[i] = ($urandom_range(0, 7) == 0) ? ^din[i] : ~^din[i];
      end
      tick();
    end

    quiet();
    for (int c = 0; c < 4; c++) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
